// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish one cycle after start; MUL/MULHU (and DIVU/REMU when
// the ALU_MC_DIV_EN macro is defined) iterate one bit per cycle over a shared 2*WIDTH accumulator.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [2*WIDTH-1:0]   acc_q, acc_step, mul_next;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     iter_res, res_q;
  logic                 zero_q;
  logic                 load_single, load_iter, finish;

  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    is_iter = op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`else
    is_iter = op inside {OP_MUL, OP_MULHU};
`endif
  endfunction

  // Reserved opcodes and (without the divider) DIVU/REMU fall to the default of 0.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_single = a + b;
      OP_SUB:  alu_single = a - b;
      OP_AND:  alu_single = a & b;
      OP_OR:   alu_single = a | b;
      OP_XOR:  alu_single = a ^ b;
      OP_SLL:  alu_single = a << sh;
      OP_SRL:  alu_single = a >> sh;
      OP_SRA:  alu_single = $unsigned(sa >>> sh);
      OP_SLT:  alu_single = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: alu_single = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_single = '0;
    endcase
  endfunction

  // Multiply: accumulator high half gathers partial sums, low half shifts the multiplier out.
  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_new;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = rem_sh >= {1'b0, opnd_q};
    rem_new  = div_ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
    div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
    acc_step = op_q[2] ? div_next : mul_next;
`else
    acc_step = mul_next;
`endif
  end

  always_comb begin
    case (op_q)
      OP_MUL, OP_DIVU:   iter_res = acc_step[WIDTH-1:0];
      OP_MULHU, OP_REMU: iter_res = acc_step[2*WIDTH-1:WIDTH];
      default:           iter_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
    load_iter   = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          if (is_iter(ALU_Operation_i)) begin
            state_d   = RUN;
            load_iter = 1'b1;
          end else begin
            state_d     = DONE;
            load_single = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load_iter) begin
        cnt_q <= SHW'(WIDTH - 1);
`ifdef ALU_MC_DIV_EN
        acc_q <= {{WIDTH{1'b0}}, (ALU_Operation_i[2] ? A_i : B_i)};
`else
        acc_q <= {{WIDTH{1'b0}}, B_i};
`endif
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - 1'b1;
        acc_q <= acc_step;
      end
      if (load_single) begin
        res_q  <= alu_single(ALU_Operation_i, A_i, B_i);
        zero_q <= (alu_single(ALU_Operation_i, A_i, B_i) == '0);
      end else if (finish) begin
        res_q  <= iter_res;
        zero_q <= (iter_res == '0);
      end
    end
  end

  // Opcode and the non-accumulator operand are frozen at capture for the whole iteration.
  always_ff @(posedge clk) begin
    if (load_iter) begin
      op_q <= ALU_Operation_i;
`ifdef ALU_MC_DIV_EN
      opnd_q <= ALU_Operation_i[2] ? B_i : A_i;
`else
      opnd_q <= A_i;
`endif
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign ALU_Result_o = res_q;
  assign Zero_o       = zero_q;

endmodule
